uart_tx_fifo: RTL and testbench

Parametrised, buffered UART transmitter: the next generation of the board-level byte sender. Callers push words into an internal FIFO and the serialiser drains it back-to-back with no per-byte handshake. Frame format (data width, stop bits, optional parity) is configurable. Sits between user logic (switches/buttons or the sensor/ESP32 link controller) and the UART pin.

---
 rtl/uart_tx_fifo.sv | 149 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter, FIFO-fed serialiser sending frames back-to-back
// Ports: clk, rst (sync active-high); i_wr_en/i_wr_data push a word; o_full, o_empty,
// o_count, o_overflow (sticky) report the FIFO; o_tx_serial is the line (idle high),
// o_tx_active spans start..last stop bit, o_tx_done pulses on the last frame cycle.
// Optional: define UART_TX_FIFO_PARITY_EN to insert a parity bit (PARITY_ODD selects odd).
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16,
    parameter int PARITY_ODD   = 0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_wr_en,
    input  logic [DATA_BITS-1:0]              i_wr_data,
    output logic                              o_full,
    output logic                              o_empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_count,
    output logic                              o_overflow,
    output logic                              o_tx_serial,
    output logic                              o_tx_active,
    output logic                              o_tx_done
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int NW = $clog2(FIFO_DEPTH+1);
    typedef enum logic [2:0] {
        IDLE, START, DATA,
`ifdef UART_TX_FIFO_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;
`ifdef UART_TX_FIFO_PARITY_EN
    localparam state_t AFTER_DATA = PARITY;
    logic par;
`else
    localparam state_t AFTER_DATA = STOP;
`endif
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [NW-1:0]        count;
    state_t               state, state_nx;
    logic [CW-1:0]        clk_cnt, clk_cnt_nx;
    logic [BW-1:0]        bit_idx, bit_idx_nx;
    logic [DATA_BITS-1:0] shreg, shreg_nx;
    logic                 tick, push, pop, serial_nx, done_nx;

    assign tick    = clk_cnt == CW'(CLKS_PER_BIT-1);
    assign push    = i_wr_en && !o_full;
    assign o_full  = count == NW'(FIFO_DEPTH);
    assign o_empty = count == '0;
    assign o_count = count;

    // The line/active/done outputs are registered from the current state, so they
    // trail the state register by one cycle; this gives the two-edge push-to-start latency.
    always_comb begin
        state_nx   = state;
        clk_cnt_nx = tick ? '0 : clk_cnt + 1'b1;
        bit_idx_nx = bit_idx;
        shreg_nx   = shreg;
        pop        = 1'b0;
        serial_nx  = 1'b1;
        done_nx    = 1'b0;
        case (state)
            IDLE: begin
                clk_cnt_nx = '0;
                if (!o_empty) begin
                    pop      = 1'b1;
                    state_nx = START;
                end
            end
            START: begin
                serial_nx = 1'b0;
                if (tick) state_nx = DATA;
            end
            DATA: begin
                serial_nx = shreg[0];
                if (tick) begin
                    shreg_nx   = shreg >> 1;
                    bit_idx_nx = bit_idx + 1'b1;
                    if (bit_idx == BW'(DATA_BITS-1)) begin
                        bit_idx_nx = '0;
                        state_nx   = AFTER_DATA;
                    end
                end
            end
`ifdef UART_TX_FIFO_PARITY_EN
            PARITY: begin
                serial_nx = par;
                if (tick) state_nx = STOP;
            end
`endif
            STOP: begin
                if (tick) begin
                    bit_idx_nx = bit_idx + 1'b1;
                    if (bit_idx == BW'(STOP_BITS-1)) begin
                        bit_idx_nx = '0;
                        done_nx    = 1'b1;
                        pop        = !o_empty;
                        state_nx   = o_empty ? IDLE : START;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
        if (pop) shreg_nx = mem[rd_ptr];
    end

    always_ff @(posedge clk) if (push) mem[wr_ptr] <= i_wr_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            o_overflow  <= 1'b0;
            state       <= IDLE;
            clk_cnt     <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            o_tx_serial <= 1'b1;
            o_tx_active <= 1'b0;
            o_tx_done   <= 1'b0;
        end else begin
            wr_ptr      <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr      <= pop ? rd_ptr + 1'b1 : rd_ptr;
            count       <= count + NW'(push) - NW'(pop);
            o_overflow  <= o_overflow || (i_wr_en && o_full);
            state       <= state_nx;
            clk_cnt     <= clk_cnt_nx;
            bit_idx     <= bit_idx_nx;
            shreg       <= shreg_nx;
            o_tx_serial <= serial_nx;
            o_tx_active <= state != IDLE;
            o_tx_done   <= done_nx;
        end
    end

`ifdef UART_TX_FIFO_PARITY_EN
    // Parity is taken from the word as it leaves the FIFO.
    always_ff @(posedge clk) begin
        if (rst) par <= 1'b0;
        else if (pop) par <= (^mem[rd_ptr]) ^ (PARITY_ODD != 0);
    end
`endif
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed scoreboard bench for uart_tx_fifo (8N1 depth-4 and 7-bit/2-stop instances)
module tb_uart_tx_fifo;
    localparam int CPB = 4;
`ifdef UART_TX_FIFO_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wa = 1'b0, wb = 1'b0;
    logic [7:0] da = '0;
    logic [6:0] db = '0;
    logic       full_a, empty_a, ovf_a, ser_a, act_a, done_a;
    logic [2:0] cnt_a;
    logic       full_b, empty_b, ovf_b, ser_b, act_b, done_b;
    logic [4:0] cnt_b;
    int n_checks = 0, n_err = 0, cyc = 0;
    int fc[2] = '{-1, -1};
    int frames[2] = '{0, 0};
    logic [15:0] slot[2];
    logic [8:0] q0[$], q1[$];
    logic [1:0] ser, act, don;
    assign ser = {ser_b, ser_a};
    assign act = {act_b, act_a};
    assign don = {done_b, done_a};

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4), .PARITY_ODD(0)) dut_a (
        .clk(clk), .rst(rst), .i_wr_en(wa), .i_wr_data(da), .o_full(full_a), .o_empty(empty_a),
        .o_count(cnt_a), .o_overflow(ovf_a), .o_tx_serial(ser_a), .o_tx_active(act_a), .o_tx_done(done_a));
    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .STOP_BITS(2), .FIFO_DEPTH(16), .PARITY_ODD(1)) dut_b (
        .clk(clk), .rst(rst), .i_wr_en(wb), .i_wr_data(db), .o_full(full_b), .o_empty(empty_b),
        .o_count(cnt_b), .o_overflow(ovf_b), .o_tx_serial(ser_b), .o_tx_active(act_b), .o_tx_done(done_b));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int ndb(int u); return u ? 7 : 8; endfunction
    function automatic int nst(int u); return u ? 2 : 1; endfunction
    function automatic int flen(int u); return (1 + ndb(u) + P + nst(u)) * CPB; endfunction

    task automatic chk(string tag, int obs, int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic frame_end(int u);
        logic [8:0] got, exp;
        got = '0;
        for (int i = 0; i < ndb(u); i++) got[i] = slot[u][1+i];
        if ((u ? q1.size() : q0.size()) == 0) begin
            chk($sformatf("unexpected frame u%0d", u), 1, 0);
            exp = got;
        end else exp = u ? q1.pop_front() : q0.pop_front();
        chk($sformatf("data u%0d", u), got, exp);
        if (P == 1) chk($sformatf("parity u%0d", u), slot[u][1+ndb(u)], (^exp) ^ u[0]);
        for (int s = 0; s < nst(u); s++) chk($sformatf("stop u%0d", u), slot[u][1+ndb(u)+P+s], 1);
        frames[u]++;
    endtask

    // Line monitor: decodes each frame mid-bit and checks active/done on every frame cycle.
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (rst) fc[u] = -1;
            else begin
                if (fc[u] < 0 && !ser[u]) fc[u] = 0;
                if (fc[u] >= 0) begin
                    if (fc[u] % CPB == CPB / 2) slot[u][fc[u] / CPB] = ser[u];
                    chk($sformatf("active u%0d", u), act[u], 1);
                    chk($sformatf("done u%0d", u), don[u], int'(fc[u] == flen(u) - 1));
                    if (fc[u] == flen(u) - 1) begin
                        frame_end(u);
                        fc[u] = -1;
                    end else fc[u]++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || fc[0] >= 0 || fc[1] >= 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain timeout", int'(n < 3000), 1);
        repeat (3) step();
    endtask

    task automatic wait_done(output int t);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done_a && n < 200);
        chk("done wait", done_a, 1);
        t = cyc;
    endtask

    initial begin
        int t1, t2, t3, f0;
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1, t2, t3, f0;
        repeat (2) step();
        @(negedge clk);
        chk("rst serial", ser_a, 1);
        chk("rst active", act_a, 0);
        chk("rst done", done_a, 0);
        chk("rst empty", empty_a, 1);
        chk("rst full", full_a, 0);
        chk("rst count", cnt_a, 0);
        chk("rst overflow", ovf_a, 0);
        step();
        rst = 1'b0;
        repeat (4) step();
        // single 0xA5 frame with exact push-to-start latency
        q0.push_back(9'hA5);
        wa = 1'b1; da = 8'hA5;
        step();
        wa = 1'b0;
        @(negedge clk);
        chk("push count", cnt_a, 1);
        chk("k serial", ser_a, 1);
        @(negedge clk);
        chk("k+1 serial", ser_a, 1);
        chk("k+1 active", act_a, 0);
        chk("k+1 count", cnt_a, 0);
        @(negedge clk);
        chk("k+2 start", ser_a, 0);
        chk("k+2 active", act_a, 1);
        drain();
        chk("idle active", act_a, 0);
        chk("idle serial", ser_a, 1);
        chk("frames A5", frames[0], 1);
        // three back-to-back frames
        for (int i = 1; i <= 3; i++) q0.push_back(9'(i));
        wa = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            da = 8'(i);
            step();
        end
        wa = 1'b0;
        @(negedge clk);
        chk("peak count", cnt_a, 2);
        wait_done(t1);
        wait_done(t2);
        chk("empty after 3rd pop", empty_a, 1);
        wait_done(t3);
        chk("gap 1-2", t2 - t1, flen(0));
        chk("gap 2-3", t3 - t2, flen(0));
        drain();
        chk("frames b2b", frames[0], 4);
        // overflow on the depth-4 FIFO while a frame is in flight
        f0 = frames[0];
        q0.push_back(9'h10);
        wa = 1'b1; da = 8'h10;
        step();
        wa = 1'b0;
        repeat (3) step();
        chk("active before burst", act_a, 1);
        wa = 1'b1;
        for (int i = 0; i < 6; i++) begin
            da = 8'(8'h20 + i);
            if (i < 4) q0.push_back(9'(8'h20 + i));
            step();
        end
        wa = 1'b0;
        @(negedge clk);
        chk("full", full_a, 1);
        chk("full count", cnt_a, 4);
        chk("overflow set", ovf_a, 1);
        drain();
        chk("overflow frames", frames[0] - f0, 5);
        chk("overflow held", ovf_a, 1);
        // reset mid-DATA with three words queued
        f0 = frames[0];
        wa = 1'b1;
        for (int i = 0; i < 4; i++) begin
            da = 8'(8'h30 + i);
            step();
        end
        wa = 1'b0;
        repeat (10) step();
        chk("queued before rst", cnt_a, 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("abort serial", ser_a, 1);
        chk("abort active", act_a, 0);
        chk("abort count", cnt_a, 0);
        chk("abort empty", empty_a, 1);
        chk("abort overflow", ovf_a, 0);
        repeat (150) step();
        chk("no frames after rst", frames[0], f0);
        chk("line idle after rst", ser_a, 1);
        // 7-bit, 2-stop instance, then 0x07 on both for parity
        q1.push_back(9'h55);
        wb = 1'b1; db = 7'h55;
        step();
        wb = 1'b0;
        drain();
        chk("frames B", frames[1], 1);
        q0.push_back(9'h07);
        q1.push_back(9'h07);
        wa = 1'b1; da = 8'h07;
        wb = 1'b1; db = 7'h07;
        step();
        wa = 1'b0; wb = 1'b0;
        drain();
        chk("frames B 0x07", frames[1], 2);
        chk("frames A 0x07", frames[0], f0 + 1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
